// File: rtl/y86_wb_regfile.sv
// Y86-64 write-back stage and 15-entry register file with two combinational read ports.
// Optional W-register read bypass is enabled with WB_FORWARD_EN.
module y86_wb_regfile #(
    parameter int unsigned NREG     = 15,
    parameter int unsigned XLEN     = 64,
    parameter logic [2:0]  STAT_AOK = 3'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic [2:0]      m_stat,
    input  logic [3:0]      m_icode,
    input  logic [3:0]      m_rA,
    input  logic [3:0]      m_rB,
    input  logic            m_cnd,
    input  logic [XLEN-1:0] m_valE,
    input  logic [XLEN-1:0] m_valM,
    input  logic [3:0]      srcA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    output logic [2:0]      stat,
    output logic            halted,
    output logic            wb_valid
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] regs [NREG];

    logic            w_valid;
    logic [2:0]      w_stat;
    logic [3:0]      w_icode;
    logic [3:0]      w_rA;
    logic [3:0]      w_rB;
    logic            w_cnd;
    logic [XLEN-1:0] w_valE;
    logic [XLEN-1:0] w_valM;

    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       capture;
    logic       commit;
    logic       commit_ok;
    logic       commit_halt;

    assign halted      = (state == S_HALT);
    assign m_ready     = !halted;
    assign wb_valid    = w_valid;
    assign capture     = m_valid && m_ready;
    assign commit      = w_valid && (state == S_RUN);
    assign commit_ok   = commit && (w_stat == STAT_AOK);
    assign commit_halt = commit && (w_stat != STAT_AOK);

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (w_icode)
            I_CMOVXX:                 dst_e = w_cnd ? w_rB : RNONE;
            I_IRMOVQ, I_OPQ:          dst_e = w_rB;
            I_MRMOVQ:                 dst_m = w_rA;
            I_CALL, I_RET, I_PUSHQ:   dst_e = RSP;
            I_POPQ: begin
                dst_e = RSP;
                dst_m = w_rA;
            end
            default: begin
                dst_e = RNONE;
                dst_m = RNONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            w_valid <= 1'b0;
            w_stat  <= STAT_AOK;
            w_icode <= '0;
            w_rA    <= RNONE;
            w_rB    <= RNONE;
            w_cnd   <= 1'b0;
            w_valE  <= '0;
            w_valM  <= '0;
            stat    <= STAT_AOK;
            state   <= S_RUN;
        end else begin
            if (commit_halt) begin
                stat  <= w_stat;
                state <= S_HALT;
            end
            // dstM is written last so it wins when both target the same register
            if (commit_ok) begin
                if (dst_e != RNONE && 32'(dst_e) < NREG) begin
                    regs[dst_e] <= w_valE;
                end
                if (dst_m != RNONE && 32'(dst_m) < NREG) begin
                    regs[dst_m] <= w_valM;
                end
            end
            // An instruction captured on the halting edge is squashed so nothing commits in HALT
            w_valid <= capture && !commit_halt;
            if (capture) begin
                w_stat  <= m_stat;
                w_icode <= m_icode;
                w_rA    <= m_rA;
                w_rB    <= m_rB;
                w_cnd   <= m_cnd;
                w_valE  <= m_valE;
                w_valM  <= m_valM;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [3:0] idx);
        logic [XLEN-1:0] r;
        r = '0;
        if (idx != RNONE && 32'(idx) < NREG) begin
            r = regs[idx];
        end
`ifdef WB_FORWARD_EN
        if (w_valid && w_stat == STAT_AOK && idx != RNONE) begin
            if (idx == dst_m) begin
                r = w_valM;
            end else if (idx == dst_e) begin
                r = w_valE;
            end
        end
`endif
        return r;
    endfunction

    always_comb begin
        valA = read_port(srcA);
        valB = read_port(srcB);
    end

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed and randomized bench for y86_wb_regfile against an instruction-level architectural model.
module tb_y86_wb_regfile;

    typedef struct packed {
        logic        v;
        logic [2:0]  st;
        logic [3:0]  ic;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [63:0] ve;
        logic [63:0] vm;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [3:0]  m_rA;
    logic [3:0]  m_rB;
    logic        m_cnd;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic        halted;
    logic        wb_valid;

    int tests = 0;
    int fails = 0;

    logic [63:0] mreg [15];
    logic [2:0]  mstat;
    logic        mhalt;
    ins_t        mw;

    y86_wb_regfile #(.NREG(15), .XLEN(64), .STAT_AOK(3'd1)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_ready(m_ready), .m_stat(m_stat), .m_icode(m_icode),
        .m_rA(m_rA), .m_rB(m_rB), .m_cnd(m_cnd), .m_valE(m_valE), .m_valM(m_valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .stat(stat), .halted(halted), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                input logic cnd, input logic [63:0] ve, input logic [63:0] vm,
                                input logic [2:0] st);
        ins_t i;
        i.v = 1'b1; i.st = st; i.ic = ic; i.ra = ra; i.rb = rb; i.cnd = cnd; i.ve = ve; i.vm = vm;
        return i;
    endfunction

    function automatic ins_t bubble();
        ins_t i;
        i = '0;
        i.st = 3'd1;
        return i;
    endfunction

    // Architectural destinations of an instruction: {dstE, dstM}, F meaning none
    function automatic logic [7:0] dsts(input ins_t i);
        case (i.ic)
            4'h2:              return {(i.cnd ? i.rb : 4'hF), 4'hF};
            4'h3, 4'h6:        return {i.rb, 4'hF};
            4'h5:              return {4'hF, i.ra};
            4'h8, 4'h9, 4'hA:  return {4'h4, 4'hF};
            4'hB:              return {4'h4, i.ra};
            default:           return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] exp_read(input logic [3:0] idx);
        logic [63:0] r;
        logic [7:0]  p;
        if (idx == 4'hF) return 64'd0;
        r = mreg[idx];
`ifdef WB_FORWARD_EN
        if (mw.v && mw.st == 3'd1) begin
            p = dsts(mw);
            if (idx == p[3:0]) r = mw.vm;
            else if (idx == p[7:4]) r = mw.ve;
        end
`else
        p = 8'hFF;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
        mstat = 3'd1;
        mhalt = 1'b0;
        mw    = bubble();
    endtask

    task automatic model_edge(input ins_t in);
        logic       was_halt;
        logic       halting;
        logic [7:0] p;
        was_halt = mhalt;
        halting  = 1'b0;
        if (mw.v && !mhalt) begin
            if (mw.st != 3'd1) begin
                mstat   = mw.st;
                mhalt   = 1'b1;
                halting = 1'b1;
            end else begin
                p = dsts(mw);
                if (p[7:4] != 4'hF) mreg[p[7:4]] = mw.ve;
                if (p[3:0] != 4'hF) mreg[p[3:0]] = mw.vm;
            end
        end
        if (in.v && !was_halt && !halting) mw = in;
        else mw = bubble();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valA", valA, exp_read(srcA));
        check("valB", valB, exp_read(srcB));
        check("stat", {61'd0, stat}, {61'd0, mstat});
        check("halted", {63'd0, halted}, {63'd0, mhalt});
        check("m_ready", {63'd0, m_ready}, {63'd0, !mhalt});
        check("wb_valid", {63'd0, wb_valid}, {63'd0, mw.v});
    endtask

    task automatic drive(input ins_t in);
        m_valid = in.v; m_stat = in.st; m_icode = in.ic; m_rA = in.ra; m_rB = in.rb;
        m_cnd = in.cnd; m_valE = in.ve; m_valM = in.vm;
    endtask

    task automatic cycle(input ins_t in, input logic [3:0] sa, input logic [3:0] sb);
        drive(in);
        srcA = sa;
        srcB = sb;
        @(posedge clk);
        model_edge(in);
        #1;
        check_all();
    endtask

    task automatic do_reset(input ins_t in);
        drive(in);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        ins_t r;
        rst = 1'b0;
        srcA = 4'd0;
        srcB = 4'd14;
        drive(bubble());
        model_reset();

        do_reset(bubble());
        check("rst_valA", valA, 64'd0);
        check("rst_valB", valB, 64'd0);
        check("rst_stat", {61'd0, stat}, 64'd1);
        check("rst_m_ready", {63'd0, m_ready}, 64'd1);

        // irmovq $101, %rdx
        cycle(mk(4'h3, 4'hF, 4'h2, 1'b0, 64'd101, 64'd0, 3'd1), 4'h2, 4'hF);
`ifdef WB_FORWARD_EN
        check("irmovq_n1", valA, 64'd101);
`else
        check("irmovq_n1", valA, 64'd0);
`endif
        cycle(bubble(), 4'h2, 4'h2);
        check("irmovq_n2", valA, 64'd101);

        // popq %rsp then popq %rbx
        cycle(mk(4'hB, 4'h4, 4'hF, 1'b0, 64'd262, 64'd77, 3'd1), 4'h4, 4'h3);
        cycle(bubble(), 4'h4, 4'h3);
        check("popq_rsp", valA, 64'd77);
        cycle(mk(4'hB, 4'h3, 4'hF, 1'b0, 64'd262, 64'd5, 3'd1), 4'h4, 4'h3);
        cycle(bubble(), 4'h4, 4'h3);
        check("popq_rbx_rsp", valA, 64'd262);
        check("popq_rbx_rbx", valB, 64'd5);

        // cmovxx: not taken, taken, then dst none
        cycle(mk(4'h2, 4'hF, 4'h1, 1'b0, 64'd9, 64'd0, 3'd1), 4'h1, 4'hF);
        cycle(bubble(), 4'h1, 4'hF);
        check("cmov_nt", valA, 64'd0);
        cycle(mk(4'h2, 4'hF, 4'h1, 1'b1, 64'd9, 64'd0, 3'd1), 4'h1, 4'hF);
        cycle(bubble(), 4'h1, 4'hF);
        check("cmov_t", valA, 64'd9);
        cycle(mk(4'h2, 4'hF, 4'hF, 1'b1, 64'd55, 64'd0, 3'd1), 4'h1, 4'hF);
        cycle(bubble(), 4'h1, 4'hF);
        check("cmov_none", valA, 64'd9);
        check("rnone_read", valB, 64'd0);

        // irmovq r0=7, halt, irmovq r0=8 streamed back to back
        cycle(mk(4'h3, 4'hF, 4'h0, 1'b0, 64'd7, 64'd0, 3'd1), 4'h0, 4'hF);
        cycle(mk(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd2), 4'h0, 4'hF);
        cycle(mk(4'h3, 4'hF, 4'h0, 1'b0, 64'd8, 64'd0, 3'd1), 4'h0, 4'hF);
        cycle(mk(4'h3, 4'hF, 4'h0, 1'b0, 64'd8, 64'd0, 3'd1), 4'h0, 4'hF);
        cycle(bubble(), 4'h0, 4'hF);
        check("halt_r0", valA, 64'd7);
        check("halt_stat", {61'd0, stat}, 64'd2);
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_m_ready", {63'd0, m_ready}, 64'd0);
        do_reset(mk(4'h3, 4'hF, 4'h0, 1'b0, 64'd8, 64'd0, 3'd1));
        srcA = 4'h0;
        #1;
        check("rst_after_halt_r0", valA, 64'd0);
        check("rst_after_halt_stat", {61'd0, stat}, 64'd1);

        // back-to-back OPq writes to r5
        cycle(mk(4'h6, 4'hF, 4'h5, 1'b0, 64'd3, 64'd0, 3'd1), 4'h5, 4'h5);
        cycle(mk(4'h6, 4'hF, 4'h5, 1'b0, 64'd4, 64'd0, 3'd1), 4'h5, 4'h5);
        check("b2b_3", mreg[5], 64'd3);
        cycle(mk(4'h6, 4'hF, 4'h5, 1'b0, 64'd5, 64'd0, 3'd1), 4'h5, 4'h5);
        check("b2b_4_rd", valA, `ifdef WB_FORWARD_EN 64'd5 `else 64'd4 `endif);
        cycle(bubble(), 4'h5, 4'h5);
        check("b2b_5_rd", valA, 64'd5);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            r.v   = ($urandom_range(0, 3) != 0);
            r.st  = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            r.ic  = 4'($urandom_range(0, 15));
            r.ra  = 4'($urandom_range(0, 15));
            r.rb  = 4'($urandom_range(0, 15));
            r.cnd = 1'($urandom_range(0, 1));
            r.ve  = {$urandom, $urandom};
            r.vm  = {$urandom, $urandom};
            if ((mhalt && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset(r);
            end else begin
                cycle(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
